// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use interlock,
// taken-redirect squash and variable-latency DMEM freeze with timeout.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [1:0]       memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_we,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt_tot
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic {S_RUN, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    waitCnt_q, waitCnt_d;
  logic             memErr_q, memErr_d;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q, waitTot_q;

  logic timeoutHit, freeze, loadUse, doFlush, doStall;

  assign timeoutHit = (state_q == S_WAIT) && (waitCnt_q == WLAST);
  assign freeze     = dmem_req_mem & ~dmem_ack & ~timeoutHit;
  assign loadUse    = (memread_ex != 2'b00) && (rd_ex != 5'd0) &&
                      ((use_rs1_id && (rs1_id == rd_ex)) ||
                       (use_rs2_id && (rs2_id == rd_ex)));

  // A redirect outranks a load-use: the dependent ID instruction is wrong-path.
  assign doFlush = ~rst & ~freeze & branch_taken_ex;
  assign doStall = ~rst & ~freeze & ~branch_taken_ex & loadUse;

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_we    = 1'b1;
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_we    = 1'b0;
    end else if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      pipe_we = 1'b0;
    end else if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (loadUse) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;
    case (state_q)
      S_RUN: begin
        if (dmem_req_mem && !dmem_ack) begin
          state_d   = S_WAIT;
          waitCnt_d = WW'(1);
        end
      end
      S_WAIT: begin
        if (!dmem_req_mem || dmem_ack) begin
          state_d   = S_RUN;
          waitCnt_d = '0;
        end else if (timeoutHit) begin
          state_d   = S_RUN;
          waitCnt_d = '0;
          memErr_d  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + WW'(1);
        end
      end
      default: begin
        state_d   = S_RUN;
        waitCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      waitCnt_q  <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      waitTot_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
      if (doStall) stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (doFlush) flushCnt_q <= flushCnt_q + CNT_W'(1);
      if (freeze)  waitTot_q  <= waitTot_q + CNT_W'(1);
    end
  end

  assign mem_err      = memErr_q;
  assign stall_cnt    = stallCnt_q;
  assign flush_cnt    = flushCnt_q;
  assign wait_cnt_tot = waitTot_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; control outputs are compared
// as {pc_we, ifid_we, ifid_flush, idex_flush, pipe_we}.
module tb_pipeline_ctrl;

  localparam logic [4:0] C_NORM   = 5'b11001;
  localparam logic [4:0] C_STALL  = 5'b00011;
  localparam logic [4:0] C_FLUSH  = 5'b11111;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_RST    = 5'b00110;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        use_rs1_id, use_rs2_id, branch_taken_ex, dmem_req_mem, dmem_ack;
  logic [1:0]  memread_ex;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, pipe_we, mem_err;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt_tot;
  logic [4:0]  ctrl;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .memread_ex(memread_ex), .rd_ex(rd_ex),
    .branch_taken_ex(branch_taken_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_we(pipe_we), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_tot(wait_cnt_tot)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_we, ifid_we, ifid_flush, idex_flush, pipe_we};

  task tick;
    @(posedge clk);
    #1;
  endtask

  task applyStimulus;
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; memread_ex = 2'b00;
    branch_taken_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ack = 1'b0;
    #1;
  endtask

  task do_reset;
    applyStimulus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task test_reset;
    applyStimulus();
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_RST) begin errors++; $display("[TB] FAIL reset_ctrl got %b exp %b", ctrl, C_RST); end
    tick();
    checks++;
    if ({mem_err, stall_cnt, flush_cnt, wait_cnt_tot} !== 97'd0) begin
      errors++; $display("[TB] FAIL reset_regs got err=%b s=%0d f=%0d w=%0d exp all 0", mem_err, stall_cnt, flush_cnt, wait_cnt_tot);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL reset_release got %b exp %b", ctrl, C_NORM); end
  endtask

  task test_load_use;
    do_reset();
    memread_ex = 2'b11; rd_ex = 5'd5; use_rs1_id = 1'b1; rs1_id = 5'd5;
    #1;
    checks++;
    if (ctrl !== C_STALL) begin errors++; $display("[TB] FAIL lu_rs1 got %b exp %b", ctrl, C_STALL); end
    tick();
    applyStimulus();
    checks++;
    if (stall_cnt !== 32'd1 || ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL lu_after got cnt=%0d ctrl=%b exp cnt=1 ctrl=%b", stall_cnt, ctrl, C_NORM);
    end
    memread_ex = 2'b11; rd_ex = 5'd0; use_rs1_id = 1'b1; rs1_id = 5'd0;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL lu_x0 got %b exp %b", ctrl, C_NORM); end
    tick();
    applyStimulus();
    memread_ex = 2'b01; rd_ex = 5'd7; use_rs2_id = 1'b1; rs2_id = 5'd7; rs1_id = 5'd3;
    #1;
    checks++;
    if (ctrl !== C_STALL) begin errors++; $display("[TB] FAIL lu_rs2 got %b exp %b", ctrl, C_STALL); end
    tick();
    use_rs2_id = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL lu_rs2_unused got %b exp %b", ctrl, C_NORM); end
    memread_ex = 2'b00; use_rs2_id = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL lu_noload got %b exp %b", ctrl, C_NORM); end
    tick();
    applyStimulus();
    checks++;
    if (stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL lu_count got %0d exp 2", stall_cnt); end
  endtask

  task test_branch_priority;
    do_reset();
    memread_ex = 2'b11; rd_ex = 5'd5; use_rs1_id = 1'b1; rs1_id = 5'd5;
    branch_taken_ex = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("[TB] FAIL br_ctrl got %b exp %b", ctrl, C_FLUSH); end
    tick();
    applyStimulus();
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd1) begin
      errors++; $display("[TB] FAIL br_counts got s=%0d f=%0d exp s=0 f=1", stall_cnt, flush_cnt);
    end
  endtask

  task test_dmem_wait;
    do_reset();
    dmem_req_mem = 1'b1; dmem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL zero_wait got %b exp %b", ctrl, C_NORM); end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_FREEZE) begin errors++; $display("[TB] FAIL wait_c1 got %b exp %b", ctrl, C_FREEZE); end
    tick();
    checks++;
    if (ctrl !== C_FREEZE) begin errors++; $display("[TB] FAIL wait_c2 got %b exp %b", ctrl, C_FREEZE); end
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL wait_ack got %b exp %b", ctrl, C_NORM); end
    tick();
    applyStimulus();
    checks++;
    if (wait_cnt_tot !== 32'd2 || mem_err !== 1'b0) begin
      errors++; $display("[TB] FAIL wait_total got w=%0d err=%b exp w=2 err=0", wait_cnt_tot, mem_err);
    end
  endtask

  // Frozen run length is measured under a cycle budget so a stuck freeze still ends.
  task test_timeout;
    int frozen;
    bit released;
    do_reset();
    frozen = 0;
    released = 1'b0;
    dmem_req_mem = 1'b1;
    #1;
    for (int i = 0; i < 40 && !released; i++) begin
      if (ctrl === C_FREEZE) frozen++;
      else released = 1'b1;
      if (!released) tick();
    end
    checks++;
    if (!released || frozen != 15 || ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL timeout_len got frozen=%0d released=%b ctrl=%b exp 15/1/%b", frozen, released, ctrl, C_NORM);
    end
    tick();
    applyStimulus();
    checks++;
    if (mem_err !== 1'b1 || wait_cnt_tot !== 32'd15) begin
      errors++; $display("[TB] FAIL timeout_err got err=%b w=%0d exp err=1 w=15", mem_err, wait_cnt_tot);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b exp 1", mem_err); end
    do_reset();
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %b exp 0", mem_err); end
  endtask

  task test_branch_freeze;
    do_reset();
    dmem_req_mem = 1'b1; branch_taken_ex = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl !== C_FREEZE) begin errors++; $display("[TB] FAIL brfz_c%0d got %b exp %b", i, ctrl, C_FREEZE); end
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("[TB] FAIL brfz_ack got %b exp %b", ctrl, C_FLUSH); end
    tick();
    applyStimulus();
    checks++;
    if (flush_cnt !== 32'd1 || wait_cnt_tot !== 32'd3) begin
      errors++; $display("[TB] FAIL brfz_counts got f=%0d w=%0d exp f=1 w=3", flush_cnt, wait_cnt_tot);
    end
  endtask

  task test_reset_mid_wait;
    do_reset();
    memread_ex = 2'b10; rd_ex = 5'd9; use_rs1_id = 1'b1; rs1_id = 5'd9;
    tick();
    applyStimulus();
    dmem_req_mem = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_RST) begin errors++; $display("[TB] FAIL midrst_ctrl got %b exp %b", ctrl, C_RST); end
    tick();
    rst = 1'b0;
    dmem_req_mem = 1'b0;
    #1;
    checks++;
    if ({mem_err, stall_cnt, flush_cnt, wait_cnt_tot} !== 97'd0 || ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL midrst_after got err=%b s=%0d f=%0d w=%0d ctrl=%b exp 0/0/0/0/%b", mem_err, stall_cnt, flush_cnt, wait_cnt_tot, ctrl, C_NORM);
    end
    // A fresh wait must again last the full 15 frozen cycles if the counter was cleared.
    dmem_req_mem = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    #1;
    checks++;
    if (ctrl !== C_NORM) begin errors++; $display("[TB] FAIL midrst_rewait got %b exp %b", ctrl, C_NORM); end
    tick();
    applyStimulus();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_dmem_wait();
    test_timeout();
    test_branch_freeze();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It takes the ID-stage register indices, the EX-stage load/branch status and the MEM-stage data-memory handshake. From these it drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sequences three cases: load-use interlock, taken-branch/jump squash, and variable-latency DMEM wait with timeout. It also keeps stall/flush performance counters.

Parameters:
TIMEOUT, 16, max cycles spent waiting for dmem_ack before forcing release (>=2)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rs1_id  in  5  rs1 field of instruction in ID
rs2_id  in  5  rs2 field of instruction in ID
use_rs1_id  in  1  ID instruction reads rs1
use_rs2_id  in  1  ID instruction reads rs2
memread_ex  in  2  MemRead of EX instruction (nonzero = load)
rd_ex  in  5  destination of EX instruction
branch_taken_ex  in  1  EX resolved taken branch/JAL/JALR (redirect valid)
dmem_req_mem  in  1  MEM stage has a load/store outstanding (level, held until acked)
dmem_ack  in  1  one-cycle DMEM completion
pc_we  out  1  PC register update enable
ifid_we  out  1  IF/ID register enable
ifid_flush  out  1  load NOP into IF/ID
idex_flush  out  1  load bubble (all controls 0) into ID/EX
pipe_we  out  1  enable for ID/EX, EX/MEM, MEM/WB
mem_err  out  1  sticky DMEM timeout flag
stall_cnt  out  CNT_W  cycles with a load-use stall
flush_cnt  out  CNT_W  taken-redirect events
wait_cnt_tot  out  CNT_W  cycles frozen for DMEM

Behaviour:
- State: RUN, WAIT; a wait counter (clog2(TIMEOUT) bits); mem_err reg; three counters.
- Reset (rst=1 at posedge): state=RUN, wait counter=0, mem_err=0, all counters=0. While rst=1, outputs are forced to pc_we=ifid_we=pipe_we=0 and ifid_flush=idex_flush=1.
- Control outputs are combinational from state, registers and inputs. Registered state/counters update on posedge clk only.
- freeze = dmem_req_mem & ~dmem_ack & ~timeout_hit, where timeout_hit = (state==WAIT && wait counter==TIMEOUT-1).
- load_use = (memread_ex!=0) & (rd_ex!=0) & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)). x0 never hazards.
- Priority (highest first): rst > freeze > branch_taken_ex > load_use > normal.
  - freeze: pc_we=ifid_we=pipe_we=0, flushes=0. The whole pipe holds, and branch_taken_ex/load_use stay held with it. They are evaluated in the cycle the freeze releases.
  - branch_taken_ex: pc_we=ifid_we=pipe_we=1, ifid_flush=idex_flush=1. This squashes the 2 wrong-path instructions. A load_use in the same cycle is ignored (its ID instruction is wrong-path). flush_cnt+1.
  - load_use: pc_we=ifid_we=0, pipe_we=1, idex_flush=1. This gives exactly one bubble. Next cycle the load is in MEM, and forwarding resolves the dependency. stall_cnt+1.
  - normal: all enables 1, flushes 0.
- FSM:
  - RUN -> WAIT when dmem_req_mem & ~dmem_ack; wait counter<=1. Zero-wait access (req & ack in the same cycle) stays in RUN with no freeze.
  - WAIT, ack=1 -> RUN; the pipeline advances in the ack cycle.
  - WAIT, ~ack and counter<TIMEOUT-1 -> WAIT; counter+1.
  - WAIT, timeout_hit -> RUN; mem_err<=1. The pipeline advances that cycle as if acked, and load data is don't-care.
  - WAIT, dmem_req_mem dropping without ack -> RUN, no error.
- wait_cnt_tot increments every cycle freeze=1.
- Counters wrap modulo 2^CNT_W. mem_err is cleared only by rst.
- Reset mid-wait: next cycle state=RUN, counters=0, no pending freeze.

Test Plan:
1. lw x5 in EX (memread_ex=2'b11, rd_ex=5), ID add reads rs1=5 -> one cycle pc_we=0, ifid_we=0, idex_flush=1, pipe_we=1; stall_cnt=1. Same with rd_ex=0 -> no stall.
2. branch_taken_ex=1 together with the load_use of test 1 -> ifid_flush=idex_flush=1, pc_we=1; stall_cnt unchanged, flush_cnt=1.
3. dmem_req_mem=1, ack at 3rd cycle -> pc_we=ifid_we=pipe_we=0 for 2 cycles, all 1 on the ack cycle; wait_cnt_tot=2, state back to RUN.
4. dmem_req_mem held, never acked, TIMEOUT=16 -> frozen exactly 15 cycles, released on the 16th, mem_err=1 and held until rst.
5. branch_taken_ex=1 during a 3-cycle DMEM freeze -> no flush while frozen; a single flush on the ack cycle; flush_cnt=1.
6. rst asserted on the 2nd wait cycle -> the next cycle shows state RUN, all counters 0, mem_err=0, normal enables once rst drops.
